// File: rtl/ysyx_22040386_clint.sv
// Core-local interruptor: mtime, mtimecmp and msip behind the MEM-stage port.
// Reads are combinational from registered state; writes commit at posedge.
module ysyx_22040386_clint #(
  parameter int unsigned TICK_DIV      = 1,
  parameter logic [63:0] ADDR_MSIP     = 64'h200_0000,
  parameter logic [63:0] ADDR_MTIMECMP = 64'h200_4000,
  parameter logic [63:0] ADDR_MTIME    = 64'h200_BFF8
) (
  input  logic        i_CLINT_clk,
  input  logic        i_CLINT_rst_n,
  input  logic [63:0] i_CLINT_addr,
  input  logic [63:0] i_CLINT_wr_data,
  input  logic        i_CLINT_wen,
  input  logic        i_CLINT_ren,
  output logic [63:0] o_CLINT_rd_data,
  output logic        o_CLINT_hit,
  output logic        o_CLINT_timer_interrupt,
  output logic        o_CLINT_soft_interrupt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [PW-1:0] presc_q, presc_d;

  logic sel_msip;
  logic sel_cmp;
  logic sel_mtime;
  logic tick;

  // Exact full-width address decode, no aliasing
  always_comb begin
    sel_msip  = (i_CLINT_addr == ADDR_MSIP);
    sel_cmp   = (i_CLINT_addr == ADDR_MTIMECMP);
    sel_mtime = (i_CLINT_addr == ADDR_MTIME);
  end

  assign o_CLINT_hit = sel_msip | sel_cmp | sel_mtime;
  assign tick        = (presc_q == PMAX);

  // Read mux returns pre-edge register state
  always_comb begin
    o_CLINT_rd_data = 64'd0;
    if (i_CLINT_ren) begin
      unique case (1'b1)
        sel_msip:  o_CLINT_rd_data = {63'd0, msip_q};
        sel_cmp:   o_CLINT_rd_data = mtimecmp_q;
        sel_mtime: o_CLINT_rd_data = mtime_q;
        default:   o_CLINT_rd_data = 64'd0;
      endcase
    end
  end

  // Next state: prescaled tick, then software writes override
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    presc_d    = presc_q;
    if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (i_CLINT_wen) begin
      unique case (1'b1)
        sel_msip: msip_d = i_CLINT_wr_data[0];
        sel_cmp:  mtimecmp_d = i_CLINT_wr_data;
        sel_mtime: begin
          mtime_d = i_CLINT_wr_data;
          presc_d = '0;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_CLINT_clk) begin
    if (!i_CLINT_rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
    end
  end

  assign o_CLINT_timer_interrupt = (mtime_q >= mtimecmp_q);
  assign o_CLINT_soft_interrupt  = msip_q;

endmodule

// File: tb/tb_ysyx_22040386_clint.sv
// Directed bench for the CLINT: one instance with TICK_DIV=1,
// one with TICK_DIV=4, sharing clock and reset.
module tb_ysyx_22040386_clint;

  localparam logic [63:0] A_MSIP  = 64'h200_0000;
  localparam logic [63:0] A_CMP   = 64'h200_4000;
  localparam logic [63:0] A_MTIME = 64'h200_BFF8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;

  logic [63:0] a1, w1, rd1;
  logic        wen1, ren1, hit1, ti1, si1;
  logic [63:0] a4, w4, rd4;
  logic        wen4, ren4, hit4, ti4, si4;

  int total = 0;
  int bad   = 0;
  longint unsigned m1;

  always #5 clk = ~clk;

  ysyx_22040386_clint #(.TICK_DIV(1)) dut1 (
    .i_CLINT_clk(clk),
    .i_CLINT_rst_n(rst_n),
    .i_CLINT_addr(a1),
    .i_CLINT_wr_data(w1),
    .i_CLINT_wen(wen1),
    .i_CLINT_ren(ren1),
    .o_CLINT_rd_data(rd1),
    .o_CLINT_hit(hit1),
    .o_CLINT_timer_interrupt(ti1),
    .o_CLINT_soft_interrupt(si1)
  );

  ysyx_22040386_clint #(.TICK_DIV(4)) dut4 (
    .i_CLINT_clk(clk),
    .i_CLINT_rst_n(rst_n),
    .i_CLINT_addr(a4),
    .i_CLINT_wr_data(w4),
    .i_CLINT_wen(wen4),
    .i_CLINT_ren(ren4),
    .o_CLINT_rd_data(rd4),
    .o_CLINT_hit(hit4),
    .o_CLINT_timer_interrupt(ti4),
    .o_CLINT_soft_interrupt(si4)
  );

  task automatic idle_all();
    a1 = 64'd0; w1 = 64'd0; wen1 = 1'b0; ren1 = 1'b0;
    a4 = 64'd0; w4 = 64'd0; wen4 = 1'b0; ren4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    a1 = A_MTIME; ren1 = 1'b1;
    #1;
    total++;
    if (rd1 !== 64'd0) begin
      bad++; $display("FAIL reset_mtime got=%h exp=0", rd1);
    end
    total++;
    if (hit1 !== 1'b1) begin
      bad++; $display("FAIL reset_hit got=%b exp=1", hit1);
    end
    total++;
    if ({ti1, si1, ti4, si4} !== 4'b0000) begin
      bad++; $display("FAIL reset_irq got=%b exp=0000", {ti1, si1, ti4, si4});
    end
    rst_n = 1'b1;
    m1 = 0;
  endtask

  task automatic test_idle_count();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (ti1 !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL idle_timer_irq got=1 exp=0");
    end
    total++;
    if (rd1 !== 64'd10) begin
      bad++; $display("FAIL idle_mtime got=%0d exp=10", rd1);
    end
  endtask

  task automatic test_compare();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0;
    repeat (5) @(negedge clk);
    m1 = 5;
    a1 = A_CMP; w1 = 64'd20; wen1 = 1'b1; ren1 = 1'b0;
    @(negedge clk);
    wen1 = 1'b0;
    m1 = 6;
    a1 = A_MTIME; ren1 = 1'b1;
    while (m1 < 25) begin
      #1;
      total++;
      if (rd1 !== m1 || ti1 !== (m1 >= 20)) begin
        bad++;
        $display("FAIL cmp_track got=%0d/%b exp=%0d/%b",
                 rd1, ti1, m1, (m1 >= 20));
      end
      @(negedge clk);
      m1++;
    end
    a1 = A_CMP; w1 = 64'd100; wen1 = 1'b1;
    @(negedge clk);
    wen1 = 1'b0;
    m1++;
    #1;
    total++;
    if (ti1 !== 1'b0) begin
      bad++; $display("FAIL cmp_raise_clear got=%b exp=0", ti1);
    end
  endtask

  task automatic test_wrap();
    a1 = A_MTIME; w1 = ONES - 64'd1; wen1 = 1'b1;
    @(negedge clk);
    a1 = A_CMP; w1 = ONES;
    @(negedge clk);
    wen1 = 1'b0;
    a1 = A_MTIME; ren1 = 1'b1;
    #1;
    total++;
    if (rd1 !== ONES || ti1 !== 1'b1) begin
      bad++; $display("FAIL wrap_top got=%h/%b exp=%h/1", rd1, ti1, ONES);
    end
    @(negedge clk);
    #1;
    total++;
    if (rd1 !== 64'd0 || ti1 !== 1'b0) begin
      bad++; $display("FAIL wrap_zero got=%h/%b exp=0/0", rd1, ti1);
    end
  endtask

  task automatic test_prescaler();
    logic [63:0] exp_a [10];
    logic [63:0] exp_b [5];
    exp_a = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd1,
              64'd1, 64'd1, 64'd1, 64'd2, 64'd2};
    exp_b = '{64'h100, 64'h100, 64'h100, 64'h100, 64'h101};
    a4 = A_MTIME; w4 = 64'd0; wen4 = 1'b1; ren4 = 1'b1;
    @(negedge clk);
    wen4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (rd4 !== exp_a[i]) begin
        bad++; $display("FAIL div4_seq[%0d] got=%0d exp=%0d", i, rd4, exp_a[i]);
      end
      @(negedge clk);
    end
    w4 = 64'h100; wen4 = 1'b1;
    @(negedge clk);
    wen4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (rd4 !== exp_b[i]) begin
        bad++; $display("FAIL div4_restart[%0d] got=%h exp=%h", i, rd4, exp_b[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    a4 = A_MTIME; w4 = 64'h55; wen4 = 1'b1; ren4 = 1'b1;
    #1;
    total++;
    if (rd4 !== 64'h101) begin
      bad++; $display("FAIL rw_same_old got=%h exp=101", rd4);
    end
    @(negedge clk);
    wen4 = 1'b0;
    #1;
    total++;
    if (rd4 !== 64'h55) begin
      bad++; $display("FAIL rw_same_new got=%h exp=55", rd4);
    end
  endtask

  task automatic test_msip_unmapped_reset();
    a1 = A_MSIP; w1 = 64'hFFFF_FFFF; wen1 = 1'b1; ren1 = 1'b1;
    @(negedge clk);
    wen1 = 1'b0;
    #1;
    total++;
    if (si1 !== 1'b1 || rd1 !== 64'd1) begin
      bad++; $display("FAIL msip_set got=%b/%h exp=1/1", si1, rd1);
    end
    a1 = 64'h200_4004; w1 = 64'd0; wen1 = 1'b1;
    #1;
    total++;
    if (hit1 !== 1'b0 || rd1 !== 64'd0) begin
      bad++; $display("FAIL unmapped got=%b/%h exp=0/0", hit1, rd1);
    end
    @(negedge clk);
    wen1 = 1'b0;
    a1 = A_CMP;
    #1;
    total++;
    if (rd1 !== ONES || si1 !== 1'b1) begin
      bad++; $display("FAIL unmapped_nochg got=%h/%b exp=%h/1", rd1, si1, ONES);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    a4 = A_MTIME; w4 = 64'h77; wen4 = 1'b1;
    @(negedge clk);
    wen4 = 1'b0;
    a1 = A_MTIME;
    #1;
    total++;
    if (rd1 !== 64'd0 || rd4 !== 64'd0) begin
      bad++; $display("FAIL rst_mtime got=%h/%h exp=0/0", rd1, rd4);
    end
    total++;
    if ({ti1, si1, ti4, si4} !== 4'b0000) begin
      bad++; $display("FAIL rst_irq got=%b exp=0000", {ti1, si1, ti4, si4});
    end
    a4 = A_CMP;
    #1;
    total++;
    if (rd4 !== ONES) begin
      bad++; $display("FAIL rst_cmp got=%h exp=%h", rd4, ONES);
    end
    rst_n = 1'b1;
    a4 = A_MTIME;
    @(negedge clk);
    #1;
    total++;
    if (rd4 !== 64'd0 || rd1 !== 64'd1) begin
      bad++; $display("FAIL rst_presc got=%h/%h exp=0/1", rd4, rd1);
    end
  endtask

  initial begin
    test_reset();
    test_idle_count();
    test_compare();
    test_wrap();
    test_prescaler();
    test_back_to_back();
    test_msip_unmapped_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
